// File: rtl/fir_out_buffer.sv
// fir_out_buffer: FWFT FIFO on the FIR sample stream with drop counting and peak capture
module fir_out_buffer #(
  parameter int DATA_W = 16,
  parameter int DEPTH  = 8,
  parameter int ADDR_W = 3
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  input  logic              out_ready,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  output logic [ADDR_W:0]   count,
  output logic              full,
  output logic              empty,
  input  logic              clr,
  output logic [15:0]       drop_cnt,
  output logic              overflow,
  output logic [DATA_W-1:0] peak
);
  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [ADDR_W-1:0] r_wr_ptr;
  logic [ADDR_W-1:0] r_rd_ptr;
  logic [ADDR_W:0]   r_count;
  logic [15:0]       r_drop_cnt;
  logic              r_overflow;
  logic [DATA_W-1:0] r_peak;
  logic              w_full;
  logic              w_empty;
  logic              w_pop;
  logic              w_push;
  logic              w_drop;

  assign w_full    = r_count == (ADDR_W+1)'(DEPTH);
  assign w_empty   = r_count == '0;
  assign w_pop     = !w_empty && out_ready;
  assign w_push    = in_valid && (!w_full || w_pop);
  assign w_drop    = in_valid && w_full && !w_pop;
  assign out_valid = !w_empty;
  assign out_data  = w_empty ? '0 : r_mem[r_rd_ptr];
  assign count     = r_count;
  assign full      = w_full;
  assign empty     = w_empty;
  assign drop_cnt  = r_drop_cnt;
  assign overflow  = r_overflow;
  assign peak      = r_peak;

  // storage is not reset; reads are masked while empty
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= in_data;
  end

  // pointers and occupancy; simultaneous push and pop leave count unchanged
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      r_wr_ptr <= w_push ? r_wr_ptr + 1'b1 : r_wr_ptr;
      r_rd_ptr <= w_pop ? r_rd_ptr + 1'b1 : r_rd_ptr;
      r_count  <= r_count + (ADDR_W+1)'(w_push) - (ADDR_W+1)'(w_pop);
    end
  end

  // debug accounting: clr wins over a same-cycle drop, peak restarts from this cycle's push
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_drop_cnt <= '0;
      r_overflow <= 1'b0;
      r_peak     <= '0;
    end else if (clr) begin
      r_drop_cnt <= '0;
      r_overflow <= 1'b0;
      r_peak     <= w_push ? in_data : '0;
    end else begin
      r_drop_cnt <= (w_drop && r_drop_cnt != 16'hFFFF) ? r_drop_cnt + 16'd1 : r_drop_cnt;
      r_overflow <= r_overflow || w_drop;
      r_peak     <= (w_push && in_data > r_peak) ? in_data : r_peak;
    end
  end
endmodule

// File: doc/fir_out_buffer.md
Name: fir_out_buffer

Overview:
- Receiving end of the FIR sample stream: accepts one filtered sample per cycle from a FIR pipeline (e.g. the 16-bit y output of fir_pipe_1).
- Buffers samples in a small FIFO and presents them to a downstream consumer over a valid/ready handshake.
- Tracks dropped samples (overflow) and the peak accepted sample value for bring-up and debug.
- Sits between the FIR datapath and any consumer (UART packer, BRAM logger, checker).

Parameters:
- DATA_W, 16, sample width in bits.
- DEPTH, 8, FIFO entries; must be a power of 2, at least 2.
- ADDR_W, 3, log2(DEPTH).

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- in_valid  input  1  in_data holds a new sample this cycle. There is no backpressure upstream.
- in_data  input  DATA_W  sample from the FIR output, unsigned.
- out_ready  input  1  downstream accepts out_data this cycle.
- out_valid  output  1  out_data holds the oldest buffered sample.
- out_data  output  DATA_W  head-of-FIFO sample (first-word-fall-through).
- count  output  ADDR_W+1  number of entries currently stored (0..DEPTH).
- full  output  1  count == DEPTH.
- empty  output  1  count == 0.
- clr  input  1  synchronous clear of drop_cnt, overflow and peak. FIFO contents are not affected.
- drop_cnt  output  16  samples lost to overflow; saturates at 16'hFFFF.
- overflow  output  1  sticky; set on the first drop and held until clr or reset.
- peak  output  DATA_W  largest sample accepted since the last reset or clr.

Behaviour:
- Reset (reset_n low, asynchronous):
  - wr_ptr = 0, rd_ptr = 0, count = 0.
  - empty = 1, full = 0, out_valid = 0.
  - drop_cnt = 0, overflow = 0, peak = 0.
  - out_data = 0 after reset; the storage array need not be reset.
- Reset asserted mid-stream: all buffered data is discarded immediately. There is no partial drain.
- Handshake:
  - pop = out_valid && out_ready. out_valid = !empty (combinational from count).
  - out_data = mem[rd_ptr]; it is valid in the same cycle the entry becomes non-empty-visible. Latency from accepted push to out_valid is 1 clock.
  - push = in_valid && (!full || pop).
  - drop = in_valid && full && !pop.
- Simultaneous events:
  - push and pop together: both pointers advance and count is unchanged. This is allowed when full; the incoming sample is stored, not dropped.
  - Empty with in_valid: push only; out_valid rises on the next cycle.
  - out_ready while empty: no effect.
- Pointers wrap modulo DEPTH. count is ADDR_W+1 bits wide so it distinguishes full from empty.
- Overflow accounting:
  - On drop: drop_cnt += 1, saturating at 16'hFFFF with no wrap; overflow <= 1.
  - The dropped sample is discarded and does not update peak.
- Peak: on push, if in_data > peak (unsigned compare), then peak <= in_data.
- clr priority:
  - clr overrides drop accounting in the same cycle: drop_cnt <= 0, overflow <= 0, and that cycle's drop is not counted.
  - On clr, peak <= in_data if push occurs that cycle, otherwise peak <= 0.
- Outputs full, empty and count are registered-state derived. There are no combinational paths from in_valid to full/empty.

Test Plan:
- Reset check: hold reset_n=0 for 3 cycles -> out_valid=0, empty=1, count=0, drop_cnt=0, overflow=0, peak=0. Then release reset_n.
- Pass-through: out_ready=1 and in_valid=1 with repeating 100,200,300,400 for 16 cycles -> out_data matches that sequence 1 cycle later, count stays ≤1, drop_cnt=0, peak=400.
- Fill and overflow: out_ready=0 and push 10 samples 1..10 -> full=1 after the 8th, drop_cnt=2, overflow=1. Then out_ready=1 -> drain returns 1..8 in order, empty=1.
- Full with simultaneous push and pop: fill to 8, then in_valid=1 with value 500 and out_ready=1 for 1 cycle -> count stays 8, drop_cnt unchanged, 500 appears as the 8th element after the current head.
- Saturation and clr: force 65,540 drops -> drop_cnt=16'hFFFF. Pulse clr in a cycle that also has a drop -> drop_cnt=0, overflow=0. Pulse clr with a push of 300 -> peak=300.
- Reset mid-operation: with count=5, assert reset_n=0 asynchronously between edges -> count=0 and out_valid=0 immediately. After release, first push of 100 -> out_data=100 next cycle.
